// File: rtl/load_store_unit.sv
// RV32I load/store stage. Builds the effective address from rs1 plus the immediate,
// checks funct3 and alignment, and runs one single-port data-memory access per operation.
module load_store_unit #(
  parameter int INSTRUCTION = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lsu_valid,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [2:0]             funct3,
  input  logic [INSTRUCTION-1:0] rs1_data,
  input  logic [INSTRUCTION-1:0] rs2_data,
  input  logic [INSTRUCTION-1:0] i_imme,
  input  logic [INSTRUCTION-1:0] s_imme,
  output logic                   busy,
  output logic                   done,
  output logic [INSTRUCTION-1:0] rd_data,
  output logic                   misalign_err,
  output logic                   bus_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [INSTRUCTION-1:0] mem_addr,
  output logic [INSTRUCTION-1:0] mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic [INSTRUCTION-1:0] mem_rdata,
  input  logic                   mem_ready
);

  // state  | meaning
  // IDLE   | waiting for an operation
  // ACCESS | memory request outstanding
  // DONE   | one-cycle completion pulse
  localparam int W  = INSTRUCTION;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    ea_q, ea_d;
  logic [W-1:0]    rs2_q, rs2_d;
  logic [W-1:0]    rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic            st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  logic            accept;
  logic [W-1:0]    ea_new;
  logic            legal;
  logic            misal;
  logic [W-1:0]    shifted;
  logic [W-1:0]    load_ext;

  assign accept = (state_q == S_IDLE) && lsu_valid && (is_load || is_store);
  assign ea_new = rs1_data + (is_store ? s_imme : i_imme);

  always_comb begin
    legal = 1'b0;
    if (is_store) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  assign misal = ((funct3[1:0] == 2'b01) && ea_new[0]) ||
                 ((funct3[1:0] == 2'b10) && (ea_new[1:0] != 2'b00));

  // Selected byte/halfword lands at bit 0 before extension.
  assign shifted = mem_rdata >> {ea_q[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{(W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(W-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (legal && !misal) ? S_ACCESS : S_DONE;
      S_ACCESS: if (mem_ready || (cnt_q == CW'(0))) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ea_d   = ea_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    f3_d   = f3_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    mis_d  = mis_q;
    berr_d = berr_q;
    if (accept) begin
      ea_d   = ea_new;
      rs2_d  = rs2_data;
      rd_d   = '0;
      f3_d   = funct3;
      st_d   = is_store;
      cnt_d  = CW'(TIMEOUT - 1);
      mis_d  = legal && misal;
      berr_d = !legal;
    end else if (state_q == S_ACCESS) begin
      // A ready in the final wait cycle completes normally rather than timing out.
      if (mem_ready) begin
        if (!st_q) rd_d = load_ext;
      end else if (cnt_q == CW'(0)) begin
        berr_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q   <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      f3_q   <= '0;
      st_q   <= 1'b0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      ea_q   <= ea_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      f3_q   <= f3_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mis_q  <= mis_d;
      berr_q <= berr_d;
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    mem_req      = (state_q == S_ACCESS);
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = 4'b0000;
    rd_data      = rd_q;
    misalign_err = mis_q;
    bus_err      = berr_q;
    if (state_q == S_ACCESS) begin
      mem_addr = {ea_q[W-1:2], 2'b00};
      mem_we   = st_q;
      if (st_q) begin
        case (f3_q[1:0])
          2'b00: begin
            mem_wdata = {(W/8){rs2_q[7:0]}};
            mem_wstrb = 4'b0001 << ea_q[1:0];
          end
          2'b01: begin
            mem_wdata = {(W/16){rs2_q[15:0]}};
            mem_wstrb = 4'b0011 << ea_q[1:0];
          end
          default: begin
            mem_wdata = rs2_q;
            mem_wstrb = 4'b1111;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the immediate generator in the RV32I R/I/L/S datapath.
- Consumes the sign-extended I-type immediate (loads) and S-type immediate (stores), together with rs1/rs2 register data.
- Forms the effective address and drives a single-port data-memory request/ready handshake.
- Returns an aligned, sign- or zero-extended load result to the writeback path.

Parameters:
- INSTRUCTION, 32, datapath, immediate and address width.
- TIMEOUT, 16, maximum number of ACCESS-state cycles spent waiting for mem_ready before bus_err is raised.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lsu_valid  in  1  operation present this cycle.
- is_load  in  1  operation is a load.
- is_store  in  1  operation is a store.
- funct3  in  3  width/sign select.
- rs1_data  in  INSTRUCTION  base address.
- rs2_data  in  INSTRUCTION  store data.
- i_imme  in  INSTRUCTION  sign-extended load offset.
- s_imme  in  INSTRUCTION  sign-extended store offset.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rd_data  out  INSTRUCTION  load result; valid while done=1.
- misalign_err  out  1  qualified by done.
- bus_err  out  1  qualified by done; covers timeout and illegal funct3.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  INSTRUCTION  word address, bits [1:0] always 0.
- mem_wdata  out  INSTRUCTION  lane-replicated store data.
- mem_wstrb  out  4  byte strobes.
- mem_rdata  in  INSTRUCTION  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  access complete.

Behaviour:
- Reset:
  - Asynchronous, active-low; state returns to IDLE immediately.
  - All outputs reset to 0.
  - Assertion mid-ACCESS drops mem_req in the same cycle; the in-flight operation is discarded with no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Accepts an operation when lsu_valid=1 and (is_load or is_store). is_store wins if both are high.
  - On accept, registers:
    - ea = rs1_data + (is_store ? s_imme : i_imme), modulo 2^32.
    - funct3, the direction, and rs2_data.
  - The validity check decides the next state:
    - Legal and aligned: go to ACCESS.
    - Otherwise: go to DONE with no memory access.
  - Legal funct3:
    - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores: 000 SB, 001 SH, 010 SW.
    - Any other value sets bus_err.
  - Misalignment sets misalign_err:
    - Halfword access with ea[0]=1.
    - Word access with ea[1:0]!=0.
    - If funct3 is illegal, the illegal-funct3 check takes precedence and misalignment is not flagged.
- lsu_valid is ignored while busy=1.
- ACCESS:
  - mem_req=1; mem_addr={ea[31:2],2'b00}; mem_we=store.
  - mem_wdata and mem_wstrb are held stable until mem_ready.
  - Store data and strobes:
    - SB: mem_wdata = rs2[7:0] replicated 4x; mem_wstrb = 4'b0001 << ea[1:0].
    - SH: mem_wdata = rs2[15:0] replicated 2x; mem_wstrb = 4'b0011 << ea[1:0].
    - SW: mem_wdata = rs2; mem_wstrb = 4'b1111.
    - Loads: mem_wstrb = 0.
  - mem_ready=1 (sampled while mem_req=1):
    - Loads capture the shifted value (mem_rdata >> 8*ea[1:0]), sign-extended (LB/LH) or zero-extended (LBU/LHU) into rd_data.
    - Next state is DONE.
  - Wait counter: counts ACCESS cycles without mem_ready. When the count reaches TIMEOUT, set bus_err, drop mem_req, and go to DONE. mem_ready arriving in that same cycle wins.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - rd_data is 0 for stores and errors.
  - Error flags are cleared on the next accept.
- Latency:
  - Accept edge, then ACCESS in the next cycle.
  - Zero-wait memory gives done 2 cycles after accept.
  - Error paths give done 1 cycle after accept.
- Throughput: with zero-wait memory, a new accept is possible in the cycle after done (3-cycle issue interval).

Test Plan:
- LW, rs1=0x1000, i_imme=0x4, mem_rdata=0xDEADBEEF, mem_ready in the first ACCESS cycle -> mem_addr=0x1004, done 2 cycles after accept, rd_data=0xDEADBEEF.
- LB at ea=0x1003 with mem_rdata=0x80FFFFFF -> rd_data=0xFFFFFF80.
- LBU at ea=0x1003 with mem_rdata=0x80FFFFFF -> rd_data=0x00000080.
- SH, rs1=0x2000, s_imme=0x2, rs2=0x1234ABCD -> mem_we=1, mem_wdata=0xABCDABCD, mem_wstrb=4'b1100.
- SB, s_imme=0xFFFFFFFF (-1) -> ea=0x1FFF, mem_addr=0x1FFC, mem_wstrb=4'b1000.
- LW at ea=0x1002 -> no mem_req; done next cycle with misalign_err=1, rd_data=0.
- funct3=011 load -> no mem_req; done next cycle with bus_err=1.
- mem_ready held low -> mem_req high for exactly TIMEOUT=16 cycles, then done with bus_err=1.
- rst_n pulsed low during ACCESS -> mem_req falls asynchronously, no done pulse, busy=0.
- Next op after the aborted one completes normally.
